tu12_tx_sched: RTL and testbench
================================

# tu12_tx_sched

Transmit byte-slot scheduler for the 21-channel TU-12 multiframe transmitter. It tracks the byte-interleaved position (channel, column, row, multiframe phase) of every TU-12 payload byte slot. It drives the one-hot enable that selects which of the 21 TU-12 generators places its byte on the shared output bus. It locks to the upstream frame and multiframe pulses, flywheels through missing pulses, and suppresses output until all generators report ready.

## Interface
- NCH, 21: number of TU-12 channels; en width and ch_id range. Fixed at 21 for this design.
- MISS_MAX, 3: consecutive missing frame pulses before lock is dropped.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- slot_vld  in  1  one TU-12 byte slot this cycle.
- fp  in  1  frame start; meaningful only with slot_vld.
- mfp  in  1  multiframe start (V1 frame); meaningful only with fp & slot_vld.
- gen_rdy  in  1  AND of all generator ready flags.
- en  out  21  one-hot generator enable; bit 20 = channel 0, bit 0 = channel 20.
- ch_id  out  5  channel number 0..20 of the current slot.
- col  out  2  TU-12 column 0..3.
- row  out  4  row 0..8.
- mf_phase  out  2  frame within multiframe, 0..3 (V1..V4).
- vbyte  out  1  slot carries a V byte (row 0, col 0).
- locked  out  1  frame alignment held.
- frm_err  out  1  one-cycle pulse: fp at an unexpected slot or lock lost.
- mf_err  out  1  one-cycle pulse: mfp received while mf_phase != 0 expected.

## Operation
- Slot order per frame: ch increments on every slot_vld (0..20). On ch wrap, col increments (0..3). On col wrap, row increments (0..8). On row wrap, mf_phase increments modulo 4.
- A frame is 21*4*9 = 756 slots. A frame boundary is the slot where ch=col=row=0.
- States: HUNT, WAIT_RDY, RUN.
- HUNT: counters held at 0, en=0, locked=0. On slot_vld&fp, this slot is ch0/col0/row0. mf_phase = 0 if mfp, else 0 is held until the first mfp arrives. Next state is WAIT_RDY.
- WAIT_RDY: counters advance on slot_vld, en=0, locked=1. At a frame boundary slot with gen_rdy=1, the FSM enters RUN and that slot is scheduled.
- RUN: each slot_vld produces en = one-hot(ch). If gen_rdy drops, en is forced 0 immediately and the state returns to WAIT_RDY; counting continues.
- fp check, WAIT_RDY and RUN:
  - fp at a non-boundary slot: frm_err pulses, counters reload to ch0/col0/row0 for that slot, and the miss counter clears.
  - fp absent at a boundary slot: the miss counter increments and the counters flywheel.
  - MISS_MAX consecutive misses: frm_err pulses, locked=0, state returns to HUNT.
  - fp present at the boundary: the miss counter clears.
- mfp check: fp&mfp at a boundary where the expected mf_phase != 0 causes mf_err to pulse and mf_phase to load 0. mfp without fp is ignored.
- Both checks can fire on the same slot. When fp&mfp arrives at a non-boundary slot, frm_err and mf_err pulse together and all counters reload to 0.
- slot_vld=0 cycles: counters hold and en=0. All other outputs hold their last value.
- vbyte = (row==0 && col==0) for the scheduled slot. The generator uses mf_phase to choose V1..V4.

## Timing
- All outputs are registered. en, ch_id, col, row, mf_phase and vbyte describe the slot presented on slot_vld one cycle earlier (latency 1).
- en is asserted for exactly one cycle per scheduled slot and is never multi-hot.
- frm_err and mf_err assert in the same cycle as the en of the offending slot.
- Reset values: en=0, ch_id=0, col=0, row=0, mf_phase=0, vbyte=0, locked=0, frm_err=0, mf_err=0, state HUNT, miss counter 0.
- Reset asserted mid-frame clears everything on the next edge. The first en after reset requires fp, then a gen_rdy boundary.
- Back-to-back slot_vld at full rate is supported with no bubbles.

## Test plan
- Lock and run: fp&mfp with gen_rdy=1, then 3024 continuous slots with fp at every 756th slot. Required response:
  - en cycles bit20..bit0 in order.
  - vbyte=1 on slots 0..20 of each frame.
  - mf_phase steps 0,1,2,3,0.
  - frm_err=0 and mf_err=0 throughout.
- Ready gating: lock with gen_rdy=0 for 2 frames, then raise gen_rdy mid-frame. Required response: en stays 0 until the next boundary, and the first en is bit20. Dropping gen_rdy at slot 100 zeroes en from the next output cycle.
- Misaligned fp: in RUN, fp arrives at slot 300. Required response: frm_err pulses once, and the next output shows ch_id=0, col=0, row=0, en bit20.
- Flywheel and loss: omit fp at 2 boundaries. Required response: counting continues, locked=1, no error. Omit 3 consecutive fp: frm_err pulses, locked=0, en=0 until a new fp.
- MF error: mfp arrives with fp at the boundary where mf_phase=2 is expected. Required response: mf_err pulses and mf_phase=0 on that slot.
- Gaps and reset: insert random slot_vld=0 gaps, then check that the sequence is identical to the gapless case. Assert rst at slot 500. Required response: all outputs at reset values next cycle, and the block re-hunts.

Source files
------------

// File: rtl/tu12_tx_sched.sv
// tu12_tx_sched: byte-slot scheduler for a 21-channel TU-12 multiframe transmitter.
// Tracks channel/column/row/multiframe position of each payload slot, locks to the
// upstream frame and multiframe pulses, flywheels through missing frame pulses and
// gates the one-hot generator enable on generator readiness.
module tu12_tx_sched #(
    parameter int NCH      = 21,
    parameter int MISS_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           slot_vld,
    input  logic           fp,
    input  logic           mfp,
    input  logic           gen_rdy,
    output logic [NCH-1:0] en,
    output logic [4:0]     ch_id,
    output logic [1:0]     col,
    output logic [3:0]     row,
    output logic [1:0]     mf_phase,
    output logic           vbyte,
    output logic           locked,
    output logic           frm_err,
    output logic           mf_err
);

    localparam int MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        WAIT_RDY = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t         state, state_nx;

    // Expected position of the next incoming slot.
    logic [4:0]     ch_q, ch_nx;
    logic [1:0]     col_q, col_nx;
    logic [3:0]     row_q, row_nx;
    logic [1:0]     mf_q, mf_nx;
    logic           sync_q, sync_nx;   // a multiframe pulse has been seen since lock
    logic [MW-1:0]  miss_q, miss_nx;

    // Effective position of the current slot after any fp/mfp realignment.
    logic [4:0]     eff_ch;
    logic [1:0]     eff_col;
    logic [3:0]     eff_row;
    logic [1:0]     eff_mf;
    logic           boundary;
    logic           sched;
    logic           frm_d, mf_d;
    logic [NCH-1:0] en_d;

    // Alignment checks, scheduling decision and next-position computation.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_nx = state;
        miss_nx  = miss_q;
        sync_nx  = sync_q;
        eff_ch   = ch_q;
        eff_col  = col_q;
        eff_row  = row_q;
        eff_mf   = mf_q;
        ch_nx    = ch_q;
        col_nx   = col_q;
        row_nx   = row_q;
        mf_nx    = mf_q;
        sched    = 1'b0;
        frm_d    = 1'b0;
        mf_d     = 1'b0;
        boundary = (ch_q == 5'd0) && (col_q == 2'd0) && (row_q == 4'd0);

        if (slot_vld) begin
            if (state == HUNT) begin
                eff_ch  = '0;
                eff_col = '0;
                eff_row = '0;
                eff_mf  = '0;
                if (fp) begin
                    state_nx = WAIT_RDY;
                    sync_nx  = mfp;
                    miss_nx  = '0;
                end
            end else begin
                if (fp) begin
                    miss_nx = '0;
                    if (!boundary) begin
                        frm_d   = 1'b1;
                        eff_ch  = '0;
                        eff_col = '0;
                        eff_row = '0;
                    end
                    if (mfp) begin
                        if (!boundary || (sync_q && mf_q != 2'd0))
                            mf_d = 1'b1;
                        eff_mf  = '0;
                        sync_nx = 1'b1;
                    end
                end else if (boundary) begin
                    if (miss_q == MW'(MISS_MAX - 1)) begin
                        frm_d    = 1'b1;
                        state_nx = HUNT;
                    end else begin
                        miss_nx = miss_q + 1'b1;
                    end
                end

                // Scheduling starts only on a frame boundary and stops at once on !gen_rdy.
                if (state_nx != HUNT) begin
                    if (!gen_rdy) begin
                        state_nx = WAIT_RDY;
                    end else if (state == RUN ||
                                 (eff_ch == 5'd0 && eff_col == 2'd0 && eff_row == 4'd0)) begin
                        state_nx = RUN;
                        sched    = 1'b1;
                    end
                end
            end

            // Advance ch -> col -> row -> multiframe phase from the effective position.
            if (state_nx == HUNT) begin
                ch_nx   = '0;
                col_nx  = '0;
                row_nx  = '0;
                mf_nx   = '0;
                sync_nx = 1'b0;
                miss_nx = '0;
            end else begin
                ch_nx  = eff_ch + 5'd1;
                col_nx = eff_col;
                row_nx = eff_row;
                mf_nx  = eff_mf;
                if (eff_ch == 5'(NCH - 1)) begin
                    ch_nx  = '0;
                    col_nx = eff_col + 2'd1;
                    if (eff_col == 2'd3) begin
                        if (eff_row == 4'd8) begin
                            row_nx = '0;
                            if (sync_nx)
                                mf_nx = eff_mf + 2'd1;
                        end else begin
                            row_nx = eff_row + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // One-hot enable: channel 0 drives the MSB.
    always_comb begin
        en_d = '0;
        for (int i = 0; i < NCH; i++)
            en_d[i] = sched && (eff_ch == 5'(NCH - 1 - i));
    end

    // State, position counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            ch_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mf_q     <= '0;
            sync_q   <= 1'b0;
            miss_q   <= '0;
            en       <= '0;
            ch_id    <= '0;
            col      <= '0;
            row      <= '0;
            mf_phase <= '0;
            vbyte    <= 1'b0;
            locked   <= 1'b0;
            frm_err  <= 1'b0;
            mf_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_nx;
            ch_q    <= ch_nx;
            col_q   <= col_nx;
            row_q   <= row_nx;
            mf_q    <= mf_nx;
            sync_q  <= sync_nx;
            miss_q  <= miss_nx;
            en      <= en_d;
            frm_err <= frm_d;
            mf_err  <= mf_d;
            if (slot_vld) begin
                ch_id    <= eff_ch;
                col      <= eff_col;
                row      <= eff_row;
                mf_phase <= eff_mf;
                vbyte    <= sched && (eff_row == 4'd0) && (eff_col == 2'd0);
                locked   <= (state_nx != HUNT);
            end
        end
    end

endmodule

// File: tb/tb_tu12_tx_sched.sv
// Self-checking bench for tu12_tx_sched: a hand-written vector table, directed
// multi-cycle sequences and randomized stimulus against a frame-position model.
module tb_tu12_tx_sched;

    localparam int NCH      = 21;
    localparam int MISS_MAX = 3;
    localparam int FRAME    = 756;

    logic           clk = 1'b0;
    logic           rst, slot_vld, fp, mfp, gen_rdy;
    logic [NCH-1:0] en;
    logic [4:0]     ch_id;
    logic [1:0]     col;
    logic [3:0]     row;
    logic [1:0]     mf_phase;
    logic           vbyte, locked, frm_err, mf_err;

    always #5 clk = ~clk;

    tu12_tx_sched #(.NCH(NCH), .MISS_MAX(MISS_MAX)) dut (
        .clk(clk), .rst(rst), .slot_vld(slot_vld), .fp(fp), .mfp(mfp), .gen_rdy(gen_rdy),
        .en(en), .ch_id(ch_id), .col(col), .row(row), .mf_phase(mf_phase),
        .vbyte(vbyte), .locked(locked), .frm_err(frm_err), .mf_err(mf_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: linear slot index within the frame ----------------
    int       m_pos, m_mf, m_miss;
    bit       m_sync, m_lk, m_run;
    logic [NCH-1:0] x_en;
    int       x_ch, x_col, x_row, x_mf;
    bit       x_vb, x_lk, x_fe, x_me;

    function automatic void model_reset();
        m_pos = 0; m_mf = 0; m_miss = 0; m_sync = 0; m_lk = 0; m_run = 0;
        x_en = '0; x_ch = 0; x_col = 0; x_row = 0; x_mf = 0;
        x_vb = 0; x_lk = 0; x_fe = 0; x_me = 0;
    endfunction

    function automatic void model_step(bit v, bit f, bit m, bit r);
        int  p, mf;
        bit  s;
        x_en = '0; x_fe = 0; x_me = 0;
        if (!v) return;
        s = 0;
        if (!m_lk) begin
            p = 0; mf = 0;
            if (f) begin m_lk = 1; m_run = 0; m_sync = m; m_miss = 0; end
        end else begin
            p = m_pos; mf = m_mf;
            if (f) begin
                m_miss = 0;
                if (p != 0) begin
                    x_fe = 1; p = 0;
                    if (m) begin x_me = 1; mf = 0; m_sync = 1; end
                end else if (m) begin
                    if (m_sync && mf != 0) x_me = 1;
                    mf = 0; m_sync = 1;
                end
            end else if (p == 0) begin
                m_miss++;
                if (m_miss == MISS_MAX) begin x_fe = 1; m_lk = 0; m_run = 0; m_miss = 0; end
            end
            if (m_lk) begin
                if (!r) m_run = 0;
                else if (m_run || p == 0) begin m_run = 1; s = 1; end
            end
        end
        x_ch = p % NCH; x_col = (p / NCH) % 4; x_row = p / (NCH * 4); x_mf = mf;
        if (s) x_en[NCH-1-x_ch] = 1'b1;
        x_vb = s && (p < NCH);
        x_lk = m_lk;
        if (!m_lk) begin
            m_pos = 0; m_mf = 0; m_sync = 0;
        end else begin
            m_pos = p + 1;
            if (m_pos == FRAME) begin
                m_pos = 0;
                if (m_sync) mf = (mf + 1) % 4;
            end
            m_mf = mf;
        end
    endfunction

    function automatic logic [63:0] exp_vec();
        return {26'd0, x_en, 5'(x_ch), 2'(x_col), 4'(x_row), 2'(x_mf), x_vb, x_lk, x_fe, x_me};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {26'd0, en, ch_id, col, row, mf_phase, vbyte, locked, frm_err, mf_err};
    endfunction

    task automatic slot(input bit v, input bit f, input bit m, input bit r);
        slot_vld = v; fp = f; mfp = m; gen_rdy = r;
        @(posedge clk);
        model_step(v, f, m, r);
        #1;
        check("slot", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        rst = 1'b1; slot_vld = 0; fp = 0; mfp = 0; gen_rdy = 0;
        @(posedge clk);
        model_reset();
        #1;
        check("reset", dut_vec(), 64'd0);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit v, f, m, r;
        logic [NCH-1:0] en;
        logic [4:0] ch;
        logic [1:0] col;
        logic [3:0] row;
        logic [1:0] mf;
        bit vb, lk, fe, me;
    } vec_t;

    vec_t tbl[10];

    int   got_mf[4];
    int   exp_mf[4] = '{1, 2, 3, 0};
    int   err_pulses, vb_cnt, en_cnt, first_k, b;
    logic [NCH-1:0] first_en, en_drop, en_before;
    bit   f, r, v, m, bnd;
    int   vcount;

    initial begin
        rst = 1'b1; slot_vld = 0; fp = 0; mfp = 0; gen_rdy = 0;
        model_reset();

        //            v  f  m  r  en          ch col row mf vb lk fe me
        tbl[0] = '{0, 0, 0, 0, 21'h000000, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 21'h000000, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 21'h000000, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{1, 0, 0, 1, 21'h000000, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 21'h000000, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 21'h100000, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[6] = '{1, 0, 0, 1, 21'h080000, 1, 0, 0, 0, 1, 1, 0, 0};
        tbl[7] = '{1, 0, 0, 0, 21'h000000, 2, 0, 0, 0, 0, 1, 0, 0};
        tbl[8] = '{1, 0, 0, 1, 21'h000000, 3, 0, 0, 0, 0, 1, 0, 0};
        tbl[9] = '{1, 1, 1, 1, 21'h100000, 0, 0, 0, 0, 1, 1, 1, 1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            slot_vld = tbl[i].v; fp = tbl[i].f; mfp = tbl[i].m; gen_rdy = tbl[i].r;
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].f, tbl[i].m, tbl[i].r);
            #1;
            check($sformatf("vec%0d", i), dut_vec(),
                  {26'd0, tbl[i].en, tbl[i].ch, tbl[i].col, tbl[i].row, tbl[i].mf,
                   tbl[i].vb, tbl[i].lk, tbl[i].fe, tbl[i].me});
        end

        // Lock and run: four frames at full rate.
        do_reset();
        slot(1, 1, 1, 1);
        err_pulses = 0; vb_cnt = 0; en_cnt = 0;
        for (int k = 1; k <= 4 * FRAME; k++) begin
            slot(1, m_pos == 0, 0, 1);
            err_pulses += int'(frm_err) + int'(mf_err);
            vb_cnt += int'(vbyte);
            en_cnt += int'(en != '0);
            if (k % FRAME == 0) got_mf[k / FRAME - 1] = int'(mf_phase);
        end
        check("run_err_pulses", 64'(err_pulses), 64'd0);
        check("run_vbyte_cnt", 64'(vb_cnt), 64'd64);
        check("run_en_cnt", 64'(en_cnt), 64'(3 * FRAME + 1));
        for (int i = 0; i < 4; i++)
            check($sformatf("mf_seq%0d", i), 64'(got_mf[i]), 64'(exp_mf[i]));

        // Ready gating: gen_rdy rises mid-frame, drops at slot 100 of the first run frame.
        do_reset();
        slot(1, 1, 1, 0);
        first_k = -1; first_en = '0; en_drop = '1; en_before = '0;
        for (int k = 1; k <= 2400; k++) begin
            r = (k >= 1600) && (k < 2268 + 100);
            slot(1, m_pos == 0, 0, r);
            if (first_k < 0 && en != '0) begin first_k = k; first_en = en; end
            if (k == 2268 + 99) en_before = en;
            if (k == 2268 + 100) en_drop = en;
        end
        check("first_en_slot", 64'(first_k), 64'd2268);
        check("first_en_val", 64'(first_en), 64'h100000);
        check("en_before_drop", 64'(en_before), 64'h20);
        check("en_after_drop", 64'(en_drop), 64'd0);

        // Misaligned fp at slot 300 while running.
        do_reset();
        slot(1, 1, 1, 1);
        for (int k = 1; k < FRAME + 300; k++) slot(1, m_pos == 0, 0, 1);
        slot(1, 1, 0, 1);
        check("misalign_frm_err", 64'(frm_err), 64'd1);
        check("misalign_pos", 64'({ch_id, col, row}), 64'd0);
        check("misalign_en", 64'(en), 64'h100000);
        err_pulses = 0;
        for (int k = 0; k < 30; k++) begin
            slot(1, 0, 0, 1);
            err_pulses += int'(frm_err);
        end
        check("misalign_single_pulse", 64'(err_pulses), 64'd0);

        // Flywheel: two misses tolerated, then three consecutive misses drop lock.
        b = 0;
        while (b < 6) begin
            bnd = (m_pos == 0) && m_lk;
            slot(1, bnd && (b == 2), 0, 1);
            if (bnd) begin
                if (b == 1) begin
                    check("fly_locked", 64'(locked), 64'd1);
                    check("fly_no_err", 64'(frm_err), 64'd0);
                end
                if (b == 5) begin
                    check("loss_frm_err", 64'(frm_err), 64'd1);
                    check("loss_locked", 64'(locked), 64'd0);
                    check("loss_en", 64'(en), 64'd0);
                end
                b++;
            end
        end
        for (int k = 0; k < 20; k++) slot(1, 0, 0, 1);
        check("hunt_en", 64'(en), 64'd0);

        // Multiframe error: mfp at the boundary where phase 2 is expected.
        do_reset();
        slot(1, 1, 1, 1);
        for (int k = 1; k < 2 * FRAME; k++) slot(1, m_pos == 0, 0, 1);
        slot(1, 1, 1, 1);
        check("mf_err_pulse", 64'(mf_err), 64'd1);
        check("mf_err_phase", 64'(mf_phase), 64'd0);
        check("mf_err_no_frm", 64'(frm_err), 64'd0);
        for (int k = 0; k < FRAME + 10; k++) slot(1, m_pos == 0, 0, 1);
        check("mf_after_reload", 64'(mf_phase), 64'd1);

        // Randomized: gaps, ready drops, stray pulses, and a reset at valid slot 500.
        do_reset();
        slot(1, 1, 1, 1);
        vcount = 0;
        for (int k = 0; k < 6000; k++) begin
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 63) != 0;
            if (m_pos == 0) f = $urandom_range(0, 7) != 0;
            else f = $urandom_range(0, 399) == 0;
            m = f ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            if (v) vcount++;
            if (vcount == 500 && v) begin
                rst = 1'b1; slot_vld = 1; fp = f; mfp = m; gen_rdy = r;
                @(posedge clk);
                model_reset();
                #1;
                check("mid_reset", dut_vec(), 64'd0);
                rst = 1'b0;
                slot(1, 0, 0, 1);
                check("rehunt_locked", 64'(locked), 64'd0);
            end else begin
                slot(v, f, m, r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
